adc_spi_reader: RTL

- SPI master for a 10-bit serial ADC (16-bit frame: 4 leading zeros, 10 data bits MSB-first, 2 trailing zeros).
- Starts conversions at a fixed rate and checks frame framing.
- Delivers adc, adc_valid and adc_err to the ADC consumer, the adc_permit block, in the feedback path.
- It is the producer end of the adc/adc_valid/adc_err interface.

---
 rtl/adc_spi_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - SPI master for a 10-bit serial ADC with periodic conversion and frame checking
module adc_spi_reader #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 80
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       sclr,
    input  logic       enable,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    input  logic       adc_sdo,
    output logic [9:0] adc,
    output logic       adc_valid,
    output logic       adc_err,
    output logic       busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(SAMPLE_PERIOD);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("adc_spi_reader: CLK_DIV must be >= 1");
        end
        if (SAMPLE_PERIOD < 2 * CLK_DIV * (16 + 1) + 1) begin : g_bad_period
            $error("adc_spi_reader: SAMPLE_PERIOD too short for one frame");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   div_cnt;
    logic            div_last;
    logic            sclk_phase;
    logic [3:0]      bit_cnt;
    logic [15:0]     shreg;
    logic [PW-1:0]   period_cnt;

    assign div_last = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else if (sclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (enable && period_cnt == '0) state_nxt = START;
            START: if (div_last) state_nxt = SHIFT;
            SHIFT: if (div_last && sclk_phase && bit_cnt == 4'd0) state_nxt = STOP;
            STOP:  if (div_last) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
        unique case (state)
            IDLE:  ;
            START: adc_cs_n = 1'b0;
            SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = sclk_phase;
            end
            STOP:  ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            div_cnt    <= '0;
            sclk_phase <= 1'b0;
            bit_cnt    <= 4'd0;
            shreg      <= 16'd0;
            period_cnt <= '0;
            adc        <= 10'd0;
            adc_err    <= 1'b0;
            adc_valid  <= 1'b0;
        end else if (sclr) begin
            div_cnt    <= '0;
            sclk_phase <= 1'b0;
            bit_cnt    <= 4'd0;
            shreg      <= 16'd0;
            period_cnt <= '0;
            adc        <= 10'd0;
            adc_err    <= 1'b0;
            adc_valid  <= 1'b0;
        end else begin
            adc_valid <= 1'b0;

            if (state == IDLE || div_last) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            // Sample on the low->high phase flip, which is the edge that raises sclk.
            if (state == START) begin
                sclk_phase <= 1'b0;
                bit_cnt    <= 4'd15;
            end else if (state == SHIFT && div_last) begin
                sclk_phase <= ~sclk_phase;
                if (!sclk_phase) begin
                    shreg <= {shreg[14:0], adc_sdo};
                end else begin
                    bit_cnt <= bit_cnt - 4'd1;
                end
            end

            if (state == IDLE && state_nxt == START) begin
                period_cnt <= PW'(SAMPLE_PERIOD - 1);
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - PW'(1);
            end

            if (state == STOP && div_cnt == '0) begin
                adc       <= shreg[11:2];
                adc_err   <= (shreg[15:12] != 4'd0) || (shreg[1:0] != 2'd0);
                adc_valid <= 1'b1;
            end
        end
    end

endmodule
